ex_mem_pipe_reg: RTL
====================

Name: ex_mem_pipe_reg

Overview:
Parametrised EX→MEM pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer.
- Adds stall (back-pressure), flush (bubble insertion), reset and a registered branch-decision output.
- Sits between the ALU/branch-adder stage and data memory, replacing the fixed-width, always-load stage register.

Parameters:
- DATA_W, 32, width of branch target, ALU result and store data.
- REG_W, 5, destination register index width.
- CTRL_W, 6, control bundle width; bit positions come from the shared package.

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- flush  in  1  kill all held entries and the current input.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept an entry.
- ctrl_in  in  CTRL_W  {Jump, MemToReg, Branch, MemRead, MemWrite, RegWrite}.
- zero_in  in  1  ALU zero flag.
- br_target_in  in  DATA_W  PC+4+(imm<<2).
- alu_result_in  in  DATA_W  ALU result / memory address.
- store_data_in  in  DATA_W  ReadData2 for stores.
- rd_in  in  REG_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM stage accepts the head entry.
- ctrl_out  out  CTRL_W  head control bits; all zero when out_valid=0.
- zero_out  out  1  head zero flag.
- br_target_out, alu_result_out, store_data_out  out  DATA_W  head data.
- rd_out  out  REG_W  head destination.
- pc_src_out  out  1  out_valid & ((Branch & zero_out) | Jump).
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage: head register H and skid register S. State is EMPTY, ONE or TWO. occupancy is 0, 1 or 2 accordingly.
- in_ready = (state != TWO). It is a function of registered state only and does not depend on out_ready combinationally.
- out_valid = (state != EMPTY). Outputs are driven from H.
- push = in_valid & in_ready. pop = out_valid & out_ready. Both are evaluated on the rising edge of clk.
- Transitions:
  - EMPTY: push → load H, go to ONE.
  - ONE: push & pop → load H, stay in ONE. Push only → load S, go to TWO. Pop only → go to EMPTY.
  - TWO: no push is possible. Pop → H←S, go to ONE.
- Latency: an entry pushed at edge N is visible on the outputs after edge N, so out_valid is high in cycle N+1. Throughput is 1 entry/cycle while out_ready=1.
- Flush has priority over push and pop. On the edge where flush=1, state goes to EMPTY and the current input is discarded. The popped head is still consumed by the MEM stage in that cycle.
- Bubble: when out_valid=0, ctrl_out=0 and pc_src_out=0. Data outputs hold their last values and are don't-care.
- The zero flag and pc_src are carried per entry; pc_src is recomputed from head contents, not from inputs.
- Reset, asynchronous at any time including mid-transfer:
  - state=EMPTY, H=S=0.
  - All outputs 0 except in_ready=1.
  - The first push is allowed on the first clk edge after Reset deasserts.
- Ordering is strictly FIFO. No entry is ever dropped or duplicated except by flush.
- Widths: all fields are stored verbatim. No arithmetic is performed other than the pc_src logic.

Decomposition:
- Shared package holds:
  - the control-bit index constants (CTRL_REGWRITE=0 … CTRL_JUMP=5);
  - CTRL_W;
  - the state encoding (EMPTY=0, ONE=1, TWO=2).
- One natural sub-module: pipe_skid_buf, a generic 2-entry skid buffer over a flattened payload vector. ex_mem_pipe_reg packs and unpacks the fields around it and adds pc_src and control zeroing.

Test Plan:
- Reset: assert Reset mid-cycle with occupancy=2 → immediately occupancy=0, out_valid=0, ctrl_out=0, in_ready=1, all data outputs 0.
- Single pass: push alu_result_in=0x0000_0040, rd_in=9, ctrl_in=6'b000001 with out_ready=1 → next cycle out_valid=1, alu_result_out=0x40, rd_out=9. One cycle later out_valid=0 and ctrl_out=0.
- Back-pressure: out_ready=0, push A=0x11 then B=0x22 → occupancy=2, in_ready=0, head=A. Third input held with in_valid=1 is not accepted. Raise out_ready → A, B, then the third entry emerge in order on consecutive cycles.
- Streaming: push and pop simultaneously each cycle for 8 values 1..8 → occupancy stays 1 and outputs are 1..8 with no gaps.
- Flush: occupancy=2 plus in_valid=1, pulse flush → next cycle occupancy=0, out_valid=0, pc_src_out=0. The flushed input never appears.
- Branch decision: push Branch=1 with zero_in=1 → pc_src_out=1. Push Branch=1 with zero_in=0 → 0. Push Jump=1 → 1. Each value appears only while its entry is at the head.

Source files
------------

// File: rtl/ex_mem_pipe_reg_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_reg_pkg
//   Shared definitions for the EX->MEM pipeline boundary register.
//   - CTRL_W and the bit position of every control signal inside the control
//     bundle {Jump, MemToReg, Branch, MemRead, MemWrite, RegWrite}.
//   - Occupancy state encoding of the 2-entry skid buffer. The numeric values
//     equal the number of entries held, so the state doubles as occupancy.
// ----------------------------------------------------------------------------
package ex_mem_pipe_reg_pkg;

  localparam int CTRL_W = 6;

  // Control bundle bit positions (LSB first).
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_JUMP     = 5;

  // Skid buffer occupancy state; value == entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Branch decision for one entry: taken branch or unconditional jump.
  function automatic logic branchTaken(input logic branch, input logic zero,
                                       input logic jump);
    return (branch & zero) | jump;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_skid.sv
// ----------------------------------------------------------------------------
// pipe_skid_buf
//   Generic 2-entry skid buffer over a flattened payload vector.
//   Head register H drives the output; skid register S catches the one entry
//   that can arrive while the head is stalled.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid & ready are both high. inReady depends on registered state only
//   (state != TWO), never combinationally on outReady, so the ready path is
//   cut at this stage. outValid = (state != EMPTY). A producer may change its
//   data only after a transfer; the buffer never drops or duplicates entries.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               empties the buffer and discards the current input
//   inValid/inReady     upstream handshake, inData payload
//   outValid/outReady   downstream handshake, outData = head payload
//   stateDbg            current occupancy state (EMPTY=0, ONE=1, TWO=2)
// ----------------------------------------------------------------------------
module pipe_skid_buf
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData,
  output logic [1:0]   stateDbg
);

  skid_state_e state;
  logic [W-1:0] headReg;
  logic [W-1:0] skidReg;
  logic         push;
  logic         pop;

  assign inReady  = (state != ST_TWO);
  assign outValid = (state != ST_EMPTY);
  assign outData  = headReg;
  assign stateDbg = state;

  assign push = inValid & inReady;
  assign pop  = outValid & outReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      headReg <= '0;
      skidReg <= '0;
    end else if (flush) begin
      // Flush wins over push/pop. A head popped this cycle was already taken
      // by the consumer; everything else, including the input, is dropped.
      // Register contents are left as-is; they are invisible while EMPTY.
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (push) begin
            headReg <= inData;
            state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            headReg <= inData;
          end else if (push) begin
            // Head is stalled: park the newcomer in the skid register.
            skidReg <= inData;
            state   <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // inReady is low here, so only a pop can happen.
          if (pop) begin
            headReg <= skidReg;
            state   <= ST_ONE;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_reg
//   EX->MEM pipeline boundary register with valid/ready handshake, a 2-entry
//   skid buffer, flush (bubble insertion) and a registered branch decision.
//
// Ports:
//   clk, Reset                rising-edge clock, async active-high reset
//   flush                     kill held entries and the current input
//   in_valid / in_ready       upstream handshake (in_ready = not full)
//   ctrl_in                   {Jump, MemToReg, Branch, MemRead, MemWrite, RegWrite}
//   zero_in, br_target_in,
//   alu_result_in,
//   store_data_in, rd_in      per-entry payload, stored verbatim
//   out_valid / out_ready     downstream handshake for the head entry
//   ctrl_out                  head control bits, forced to 0 in a bubble
//   zero_out, br_target_out,
//   alu_result_out,
//   store_data_out, rd_out    head payload (hold last value in a bubble)
//   pc_src_out                out_valid & ((Branch & zero_out) | Jump)
//   occupancy                 entries held, 0..2
// ----------------------------------------------------------------------------
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] br_target_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] br_target_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              pc_src_out,
  output logic [1:0]        occupancy
);

  // Flattened payload layout, MSB first:
  //   {ctrl, zero, br_target, alu_result, store_data, rd}
  localparam int PAY_W = CTRL_W + 1 + 3 * DATA_W + REG_W;

  logic [PAY_W-1:0]  inPayload;
  logic [PAY_W-1:0]  headPayload;
  logic [CTRL_W-1:0] headCtrl;
  logic              headValid;
  logic [1:0]        bufState;

  assign inPayload = {ctrl_in, zero_in, br_target_in, alu_result_in,
                      store_data_in, rd_in};

  pipe_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (Reset),
    .flush    (flush),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .inData   (inPayload),
    .outValid (headValid),
    .outReady (out_ready),
    .outData  (headPayload),
    .stateDbg (bufState)
  );

  assign {headCtrl, zero_out, br_target_out, alu_result_out, store_data_out,
          rd_out} = headPayload;

  assign out_valid = headValid;
  assign occupancy = bufState;

  // A bubble must not carry live control into MEM, so control is masked;
  // data fields are don't-care downstream and pass through unmasked.
  assign ctrl_out = headValid ? headCtrl : '0;

  // Branch decision comes from the stored head entry, never from the inputs.
  assign pc_src_out = headValid & branchTaken(headCtrl[CTRL_BRANCH], zero_out,
                                              headCtrl[CTRL_JUMP]);

endmodule
